// File: rtl/clk_divider_multi.sv
// Multi-channel programmable integer clock divider.
// Each channel emits a one-cycle tick every D enabled cycles and a 50% square wave of period 2*D.
module clk_divider_multi #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned RESET_DIV = 0
) (
  input  logic                        i_sys_clk,
  input  logic                        i_sys_rst,
  input  logic [$clog2(CHANNELS)-1:0] i_ch_sel,
  input  logic [DIV_W-1:0]            i_div_value,
  input  logic                        i_div_load,
  input  logic [CHANNELS-1:0]         i_ch_enable,
  output logic [CHANNELS-1:0]         o_tick,
  output logic [CHANNELS-1:0]         o_block_clk,
  output logic [CHANNELS-1:0]         o_div_pending
);

  localparam int unsigned SEL_W = $clog2(CHANNELS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] r_pend_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_tick;
    logic             r_bclk;

    logic [DIV_W-1:0] w_active_nxt;
    logic [DIV_W-1:0] w_pend_div_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_pending_nxt;
    logic             w_tick_nxt;
    logic             w_bclk_nxt;
    logic             w_load_hit;
    logic             w_running;
    logic             w_tc;

    // A select at or beyond CHANNELS matches no channel, so such loads are dropped.
    assign w_load_hit = i_div_load && (i_ch_sel == SEL_W'(g));
    assign w_running  = i_ch_enable[g] && (r_active != '0);
    assign w_tc       = w_running && (r_cnt == (r_active - DIV_W'(1)));

    always_comb begin
      w_active_nxt   = r_active;
      w_pend_div_nxt = r_pend_div;
      w_cnt_nxt      = r_cnt;
      w_pending_nxt  = r_pending;
      w_tick_nxt     = 1'b0;
      w_bclk_nxt     = r_bclk;

      if (!w_running) begin
        w_cnt_nxt  = '0;
        w_bclk_nxt = 1'b0;
        if (w_load_hit) begin
          w_active_nxt  = i_div_value;
          w_pending_nxt = 1'b0;
        end
      end else if (w_tc) begin
        // Period boundary: a same-cycle load beats an older pending value.
        w_cnt_nxt     = '0;
        w_tick_nxt    = 1'b1;
        w_bclk_nxt    = ~r_bclk;
        w_pending_nxt = 1'b0;
        if (w_load_hit) begin
          w_active_nxt = i_div_value;
        end else if (r_pending) begin
          w_active_nxt = r_pend_div;
        end
      end else begin
        w_cnt_nxt = r_cnt + DIV_W'(1);
        if (w_load_hit) begin
          w_pend_div_nxt = i_div_value;
          w_pending_nxt  = 1'b1;
        end
      end
    end

    always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
        r_active   <= DIV_W'(RESET_DIV);
        r_pend_div <= '0;
        r_cnt      <= '0;
        r_pending  <= 1'b0;
        r_tick     <= 1'b0;
        r_bclk     <= 1'b0;
      end else begin
        r_active   <= w_active_nxt;
        r_pend_div <= w_pend_div_nxt;
        r_cnt      <= w_cnt_nxt;
        r_pending  <= w_pending_nxt;
        r_tick     <= w_tick_nxt;
        r_bclk     <= w_bclk_nxt;
      end
    end

    assign o_tick[g]        = r_tick;
    assign o_block_clk[g]   = r_bclk;
    assign o_div_pending[g] = r_pending;
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Self-checking bench for clk_divider_multi: directed scenarios then random loads/enables/resets,
// compared cycle by cycle against a period-tracking reference model.
module tb_clk_divider_multi;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned RDIV  = 0;

  logic           clk;
  logic           rst;
  logic [1:0]     sel;
  logic [DW-1:0]  val;
  logic           load;
  logic [NCH-1:0] en;
  logic [NCH-1:0] o_tick;
  logic [NCH-1:0] o_bclk;
  logic [NCH-1:0] o_pend;

  int n_checks;
  int n_fail;

  // Reference model: divide value, queued value, cycles elapsed in current period.
  int m_act  [NCH];
  int m_pv   [NCH];
  int m_el   [NCH];
  bit m_pend [NCH];
  bit m_tick [NCH];
  bit m_bclk [NCH];

  clk_divider_multi #(
    .CHANNELS  (NCH),
    .DIV_W     (DW),
    .RESET_DIV (RDIV)
  ) dut (
    .i_sys_clk     (clk),
    .i_sys_rst     (rst),
    .i_ch_sel      (sel),
    .i_div_value   (val),
    .i_div_load    (load),
    .i_ch_enable   (en),
    .o_tick        (o_tick),
    .o_block_clk   (o_bclk),
    .o_div_pending (o_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update();
    bit hit;
    for (int c = 0; c < NCH; c++) begin
      hit = load && (int'(sel) == c);
      if (rst) begin
        m_act[c] = RDIV; m_pv[c] = 0; m_pend[c] = 0;
        m_el[c] = 0; m_tick[c] = 0; m_bclk[c] = 0;
      end else if (!en[c] || m_act[c] == 0) begin
        m_el[c] = 0; m_tick[c] = 0; m_bclk[c] = 0;
        if (hit) begin
          m_act[c] = int'(val); m_pend[c] = 0;
        end
      end else begin
        m_el[c]++;
        if (m_el[c] == m_act[c]) begin
          m_el[c] = 0; m_tick[c] = 1; m_bclk[c] = !m_bclk[c];
          if (hit) m_act[c] = int'(val);
          else if (m_pend[c]) m_act[c] = m_pv[c];
          m_pend[c] = 0;
        end else begin
          m_tick[c] = 0;
          if (hit) begin
            m_pv[c] = int'(val); m_pend[c] = 1;
          end
        end
      end
    end
  endtask

  task automatic step();
    logic [NCH-1:0] et, eb, ep;
    @(posedge clk);
    model_update();
    #1;
    for (int c = 0; c < NCH; c++) begin
      et[c] = m_tick[c]; eb[c] = m_bclk[c]; ep[c] = m_pend[c];
    end
    chk("tick", 32'(o_tick), 32'(et));
    chk("block_clk", 32'(o_bclk), 32'(eb));
    chk("div_pending", 32'(o_pend), 32'(ep));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load_ch(input int c, input int v);
    sel = 2'(c); val = DW'(v); load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; load = 1'b0; sel = '0; val = '0; en = '0;
    run(2);
    chk("reset_outputs", 32'({o_tick, o_bclk, o_pend}), 32'd0);
    rst = 1'b0;

    // Channel 0, D=5 loaded while halted-but-enabled: ticks at 5,10,15 after load.
    en = 4'b0001;
    load_ch(0, 5);
    run(16);

    // Channel 1 D=4, then D=7 queued at count 1.
    en = 4'b0011;
    load_ch(1, 4);
    for (int k = 0; k < 20 && m_el[1] != 1; k++) step();
    load_ch(1, 7);
    run(20);

    // Pending 9 overridden by 3 arriving exactly on terminal count.
    for (int k = 0; k < 20 && m_el[1] != 1; k++) step();
    load_ch(1, 9);
    for (int k = 0; k < 20 && m_el[1] != m_act[1] - 1; k++) step();
    load_ch(1, 3);
    run(12);

    // Channel 2 D=1, then D=0 halts at boundary.
    en = 4'b0111;
    load_ch(2, 1);
    run(6);
    load_ch(2, 0);
    run(4);

    // Drop enable on channel 0 mid-period, load D=6 while halted, re-enable.
    for (int k = 0; k < 20 && m_el[0] != 2; k++) step();
    en[0] = 1'b0;
    step();
    load_ch(0, 6);
    step();
    en[0] = 1'b1;
    run(14);

    // Reset collides with a load; every channel mid-count.
    en = 4'b1111;
    load_ch(3, 5);
    load_ch(2, 4);
    run(3);
    rst = 1'b1; sel = 2'd3; val = DW'(8); load = 1'b1;
    step();
    chk("rst_with_load", 32'({o_tick, o_bclk, o_pend}), 32'd0);
    rst = 1'b0; load = 1'b0;
    run(12);
    chk("halted_after_rst", 32'({o_tick, o_bclk}), 32'd0);

    // Randomized loads, enables and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        sel  = 2'($urandom_range(0, NCH - 1));
        val  = DW'(($urandom_range(0, 15) == 0) ? 1 : $urandom_range(0, 12));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) en = NCH'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0; load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_divider_multi.md
# clk_divider_multi

Parametrised multi-channel successor to the single-channel power-of-two clock divider. Each channel divides `sys_clk` by an arbitrary programmable integer. Each channel provides a one-cycle `tick` enable and a 50 %-duty `block_clk` square wave. Divide values are reprogrammed at run time through a shared load port and take effect glitch-free at the channel's next period boundary. The block sits between the board-level clock/reset and downstream display-scan, debounce and animation blocks that need independent rates.

## Interface
- `CHANNELS`, 4: number of independent divider channels; must be ≥ 2.
- `DIV_W`, 16: width of the divide value and the per-channel counter.
- `RESET_DIV`, 0: divide value loaded into every channel on reset; 0 means halted.
- `sys_clk`  in  1  system clock; every register is clocked on its rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `ch_sel`  in  $clog2(CHANNELS)  channel addressed by `div_load`.
- `div_value`  in  DIV_W  new divide value D for the addressed channel.
- `div_load`  in  1  single-cycle strobe that writes `div_value` to channel `ch_sel`.
- `ch_enable`  in  CHANNELS  per-channel run enable.
- `tick`  out  CHANNELS  one-cycle pulse every D enabled cycles, registered.
- `block_clk`  out  CHANNELS  square wave that toggles on every tick (period 2·D), registered.
- `div_pending`  out  CHANNELS  high while a loaded value waits for the period boundary.

## Operation
- Per-channel state:
  - `active_div` [DIV_W]
  - `pending_div` [DIV_W]
  - `pending` flag
  - `cnt` [DIV_W]
  - `tick` and `block_clk` registers
- Channel states:
  - HALTED: `active_div` == 0, or `ch_enable` low.
  - RUNNING: otherwise.
- RUNNING, `cnt` ≠ `active_div`−1:
  - `cnt` increments.
  - `tick` <= 0.
- RUNNING, `cnt` == `active_div`−1 (terminal count):
  - `cnt` <= 0.
  - `tick` <= 1.
  - `block_clk` toggles.
  - If `pending` is set: `active_div` <= `pending_div` and `pending` <= 0.
- HALTED:
  - `cnt` <= 0.
  - `tick` <= 0.
  - `block_clk` <= 0.
- Load when `div_load` is high and `ch_sel` < CHANNELS:
  - Target HALTED: `active_div` <= `div_value`, `cnt` <= 0, `pending` <= 0. The new value is applied immediately.
  - Target RUNNING: `pending_div` <= `div_value`, `pending` <= 1.
  - Load in the same cycle as the target's terminal count: `div_value` goes directly to `active_div` (the fresh value wins), and `pending` <= 0.
  - Second load before the boundary: overwrites `pending_div`. Only the last value is applied.
- Load when `ch_sel` ≥ CHANNELS: ignored, with no state change.
- D = 1 while RUNNING: `tick` held high continuously and `block_clk` = `sys_clk`/2.
- Loading D = 0 into a RUNNING channel: the channel halts at its next period boundary, and `block_clk` drops low one cycle later.
- Width: `cnt` compares against `active_div`−1 in DIV_W bits. The maximum D = 2^DIV_W−1 gives ticks every 2^DIV_W−1 cycles. `cnt` never wraps past `active_div`−1.
- `div_pending` = `pending` for each channel.

## Timing
- Reset (`sys_rst` high at an edge):
  - `tick`, `block_clk`, `div_pending` and every `cnt` go to 0.
  - `active_div` <= RESET_DIV.
  - `pending_div` <= 0.
  - Reset overrides a `div_load` in the same cycle. Reset mid-period discards any partial count.
- With `ch_enable` high from edge 0 and D active:
  - `tick` is high after edges D, 2D, 3D, …
  - `block_clk` toggles at those same edges.
- A pending value takes effect at the next terminal-count edge. The following tick arrives exactly D_new cycles later, with no shortened or stretched period.
- Deassert `ch_enable`: `block_clk` and `tick` are low after the next edge.
- Reassert `ch_enable`: the first tick comes D cycles after the first enabled edge.
- Immediate load into a HALTED but enabled channel: the first tick comes D cycles after the load edge.
- Channels are fully independent and a load affects only `ch_sel`. There is no cross-channel phase alignment.

## Test plan
- Reset, then load D = 5 on channel 0 with `ch_enable` = 0001 → `tick[0]` high at cycles 5, 10, 15 after load; `block_clk[0]` period 10, duty 5/5; other channels stay 0.
- Channel 1 running with D = 4; load D = 7 at count 1 → `div_pending[1]` high until the next tick; the remaining ticks of the old period are 4 apart, then spacing becomes 7; no shortened period.
- Load arriving exactly on a terminal count with `pending` already set (pending = 9, new = 3) → next spacing is 3; `div_pending` clears the same edge.
- D = 1 on channel 2 → `tick[2]` constantly high; `block_clk[2]` toggles every cycle. Then load D = 0 → `tick[2]` low and `block_clk[2]` low after the boundary.
- Drop `ch_enable[0]` mid-period, then re-raise after 3 cycles with D = 6 → outputs low after one edge; first tick 6 cycles after re-enable.
- Assert `sys_rst` together with `div_load` (`ch_sel` = 3, D = 8) and mid-count on all channels → all outputs 0 next cycle; the load is not applied; `active_div` = RESET_DIV. A load with `ch_sel` ≥ CHANNELS is ignored.
